// File: rtl/bus_pkg.sv
// Shared types and frame constants for the serial bus slave port.
// Frame lengths are in bits; ACK_LEN_DEF is the default ack window length.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WR_ACK,
    ST_RD_FETCH,
    ST_RDATA
  } bus_slv_state_t;

  localparam int ADDR_FRAME_LEN = 16;
  localparam int DATA_FRAME_LEN = 8;
  localparam int ACK_LEN_DEF    = 4;

endpackage

// File: rtl/bus_slave_port_counter.sv
// Bit/window counter shared by all slave frame phases.
// Synchronous clear has priority over increment.
module bus_slave_port_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bus_slave_port.sv
// Serial bus slave: deserialises address/write frames, acks the master,
// drives a local memory port and serialises read data back LSB first.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int               ADDR_W   = 12,
  parameter logic [15-ADDR_W:0] SLAVE_ID = 4'h1,
  parameter int               ACK_LEN  = ACK_LEN_DEF,
  parameter int               TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              B_UTIL,
  input  logic              B_RW,
  input  logic              B_BUS_IN,
  output logic              B_BUS_OUT,
  output logic              B_ACK,
  output logic [ADDR_W-1:0] S_ADDR,
  output logic [7:0]        S_WDATA,
  output logic              S_WEN,
  output logic              S_REN,
  input  logic [7:0]        S_RDATA,
  output logic              S_BSY
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] A_LAST = 4'(ADDR_FRAME_LEN - 1);
  localparam logic [3:0] D_LAST = 4'(DATA_FRAME_LEN - 1);
  localparam logic [3:0] K_LAST = 4'(ACK_LEN - 1);
  localparam logic [3:0] K_ON   = 4'(ACK_LEN - 2);

  localparam logic [GAP_W-1:0] G_LAST = GAP_W'(TIMEOUT - 1);

  bus_slv_state_t state_q, state_d;

  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              timeout;
  logic              hit_q;
  logic              hit_d;

  logic [15:0]       addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        wdata_nx;
  logic [7:0]        rdata_q, rdata_d;
  logic              bout_q, bout_d;
  logic              bout_nx;
  logic              ack_q, ack_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;

  bus_slave_port_counter #(
    .WIDTH (4)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RSTN),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  assign hit_q = (addr_q[15:ADDR_W] == SLAVE_ID);

  // Consecutive idle cycles inside a serial frame
  always_comb begin
    gap_d   = '0;
    timeout = 1'b0;
    if ((state_q == ST_ADDR || state_q == ST_WDATA ||
         state_q == ST_RDATA) && !B_UTIL) begin
      timeout = (gap_q == G_LAST);
      gap_d   = timeout ? '0 : gap_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (B_UTIL) begin
          state_d = ST_ADDR;
          cnt_inc = 1'b1;
        end
      end
      ST_ADDR: begin
        if (timeout) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (B_UTIL) begin
          if (cnt == A_LAST) begin
            state_d = ST_ADDR_ACK;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_ADDR_ACK: begin
        if (cnt == K_LAST) begin
          cnt_clr = 1'b1;
          if (!hit_q) begin
            state_d = ST_IDLE;
          end else if (rw_q) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_RD_FETCH;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WDATA: begin
        if (timeout) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (B_UTIL) begin
          if (cnt == D_LAST) begin
            state_d = ST_WR_ACK;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_WR_ACK: begin
        if (cnt == K_LAST) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RD_FETCH: begin
        // Cycle 0 strobes the read, cycle 1 sees the returned byte
        if (cnt == 4'd1) begin
          state_d = ST_RDATA;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RDATA: begin
        if (timeout) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (B_UTIL) begin
          if (cnt == D_LAST) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign cnt_n = cnt_clr ? 4'd0 : (cnt_inc ? cnt + 4'd1 : cnt);

  // Serial capture and shift datapath
  always_comb begin
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_nx = wdata_q;
    rdata_d  = rdata_q;
    bout_nx  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (B_UTIL) begin
          addr_d = {15'd0, B_BUS_IN};
        end
      end
      ST_ADDR: begin
        if (B_UTIL) begin
          addr_d[cnt] = B_BUS_IN;
          if (cnt == A_LAST) begin
            rw_d = B_RW;
          end
        end
      end
      ST_WDATA: begin
        if (B_UTIL) begin
          wdata_nx[cnt[2:0]] = B_BUS_IN;
        end
      end
      ST_RD_FETCH: begin
        if (cnt == 4'd1) begin
          rdata_d = S_RDATA;
        end
      end
      ST_RDATA: begin
        bout_nx = B_UTIL ? rdata_q[cnt[2:0]] : bout_q;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    hit_d   = (addr_d[15:ADDR_W] == SLAVE_ID);
    saddr_d = saddr_q;
    wdata_d = wdata_nx;
    bout_d  = timeout ? 1'b0 : bout_nx;
    if (state_q == ST_ADDR && state_d == ST_ADDR_ACK && hit_d) begin
      saddr_d = addr_d[ADDR_W-1:0];
    end
    if (state_d == ST_IDLE) begin
      saddr_d = '0;
      wdata_d = '0;
    end
    ack_d = (cnt_n >= K_ON) &&
            (state_d == ST_WR_ACK ||
             (state_d == ST_ADDR_ACK && hit_d));
    wen_d = (state_q == ST_WDATA) && (state_d == ST_WR_ACK);
    ren_d = (state_q == ST_ADDR_ACK) && (state_d == ST_RD_FETCH);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      bout_q  <= 1'b0;
      ack_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      bout_q  <= bout_d;
      ack_q   <= ack_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      saddr_q <= saddr_d;
    end
  end

  assign B_BUS_OUT = bout_q;
  assign B_ACK     = ack_q;
  assign S_ADDR    = saddr_q;
  assign S_WDATA   = wdata_q;
  assign S_WEN     = wen_q;
  assign S_REN     = ren_q;
  assign S_BSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: behavioural master plus memory,
// directed scenarios followed by randomized transactions.
module tb_bus_slave_port;

  localparam int ACK_LEN = 4;
  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        B_UTIL = 1'b0;
  logic        B_RW = 1'b0;
  logic        B_BUS_IN = 1'b0;
  logic        B_BUS_OUT;
  logic        B_ACK;
  logic [11:0] S_ADDR;
  logic [7:0]  S_WDATA;
  logic        S_WEN;
  logic        S_REN;
  logic [7:0]  S_RDATA;
  logic        S_BSY;

  int nvec = 0;
  int nerr = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;

  bit [7:0] mem [int];
  bit [7:0] ref_mem [int];

  bus_slave_port dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .B_UTIL    (B_UTIL),
    .B_RW      (B_RW),
    .B_BUS_IN  (B_BUS_IN),
    .B_BUS_OUT (B_BUS_OUT),
    .B_ACK     (B_ACK),
    .S_ADDR    (S_ADDR),
    .S_WDATA   (S_WDATA),
    .S_WEN     (S_WEN),
    .S_REN     (S_REN),
    .S_RDATA   (S_RDATA),
    .S_BSY     (S_BSY)
  );

  always #5 CLK = ~CLK;

  // Memory: read data valid only in the cycle after S_REN
  always @(posedge CLK) begin
    if (S_WEN) begin
      mem[int'(S_ADDR)] = S_WDATA;
      wen_cnt++;
    end
    if (S_REN) begin
      ren_cnt++;
    end
    if (S_REN && mem.exists(int'(S_ADDR))) begin
      S_RDATA <= mem[int'(S_ADDR)];
    end else if (S_REN) begin
      S_RDATA <= 8'h00;
    end else begin
      S_RDATA <= 8'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic u, input logic b);
    B_UTIL   = u;
    B_BUS_IN = b;
    @(negedge CLK);
  endtask

  task automatic quiet(input string tag);
    chk({tag, ".ack"}, 16'(B_ACK), 16'd0);
    chk({tag, ".wen"}, 16'(S_WEN), 16'd0);
    chk({tag, ".ren"}, 16'(S_REN), 16'd0);
    chk({tag, ".bsy"}, 16'(S_BSY), 16'd1);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".bout"}, 16'(B_BUS_OUT), 16'd0);
    chk({tag, ".ack"}, 16'(B_ACK), 16'd0);
    chk({tag, ".saddr"}, 16'(S_ADDR), 16'd0);
    chk({tag, ".wdata"}, 16'(S_WDATA), 16'd0);
    chk({tag, ".wen"}, 16'(S_WEN), 16'd0);
    chk({tag, ".ren"}, 16'(S_REN), 16'd0);
    chk({tag, ".bsy"}, 16'(S_BSY), 16'd0);
  endtask

  task automatic send(input logic [15:0] v, input int n,
                      input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, v[i]);
      if (i != n - 1) quiet("frame");
      if (i == gap_at && i != n - 1) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc(1'b0, 1'($urandom));
          quiet("gap");
        end
      end
    end
  endtask

  task automatic window(input bit hit, input bit wr,
                        input logic [11:0] a, input logic [7:0] d);
    for (int i = 0; i < ACK_LEN; i++) begin
      chk("ack", 16'(B_ACK), 16'(hit && i >= ACK_LEN - 2));
      chk("wen", 16'(S_WEN), 16'(wr && i == 0));
      chk("ren_win", 16'(S_REN), 16'd0);
      if (hit) chk("saddr", 16'(S_ADDR), 16'(a));
      if (wr && i == 0) chk("wdata", 16'(S_WDATA), 16'(d));
      cyc(1'b0, 1'($urandom));
    end
  endtask

  task automatic recv(input logic [7:0] exp, input int gap_at,
                      input int gap_len);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'($urandom));
      chk("bout", 16'(B_BUS_OUT), 16'(exp[i]));
      chk("rd_bsy", 16'(S_BSY), 16'(i < 7));
      if (i == gap_at && i < 7) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc(1'b0, 1'($urandom));
          chk("hold", 16'(B_BUS_OUT), 16'(exp[i]));
        end
      end
    end
    cyc(1'b0, 1'b0);
    chk("bout_idle", 16'(B_BUS_OUT), 16'd0);
  endtask

  task automatic txn(input logic [15:0] a, input bit wr,
                     input logic [7:0] d, input int gap_at,
                     input int gap_len);
    bit         hit;
    logic [7:0] exp;
    int         w0;
    int         r0;
    hit = (a[15:12] == 4'h1);
    w0  = wen_cnt;
    r0  = ren_cnt;
    B_RW = wr;
    send(a, 16, -1, 0);
    window(hit, 1'b0, a[11:0], 8'h00);
    if (!hit) begin
      chk("miss_idle", 16'(S_BSY), 16'd0);
    end else if (wr) begin
      send({8'h00, d}, 8, gap_at, gap_len);
      window(1'b1, 1'b1, a[11:0], d);
      ref_mem[int'(a[11:0])] = d;
      chk("wr_idle", 16'(S_BSY), 16'd0);
    end else begin
      exp = ref_mem.exists(int'(a[11:0])) ?
            ref_mem[int'(a[11:0])] : 8'h00;
      chk("ren", 16'(S_REN), 16'd1);
      cyc(1'b0, 1'b0);
      chk("ren_off", 16'(S_REN), 16'd0);
      cyc(1'b0, 1'b0);
      recv(exp, gap_at, gap_len);
    end
    chk("wen_pulses", 16'(wen_cnt - w0), 16'(hit && wr));
    chk("ren_pulses", 16'(ren_cnt - r0), 16'(hit && !wr));
  endtask

  initial begin
    logic [15:0] a;
    int          w0;

    @(negedge CLK);
    all_zero("reset");
    RSTN = 1'b1;
    @(negedge CLK);

    txn(16'h1234, 1'b1, 8'hA5, -1, 0);

    mem[12'h0FF] = 8'h3C;
    ref_mem[12'h0FF] = 8'h3C;
    txn(16'h10FF, 1'b0, 8'h00, -1, 0);

    txn(16'h2234, 1'b1, 8'h5A, -1, 0);

    mem[12'h055] = 8'h81;
    ref_mem[12'h055] = 8'h81;
    txn(16'h1055, 1'b0, 8'h00, 3, 5);

    B_RW = 1'b1;
    send(16'h1777, 8, -1, 0);
    quiet("pre_to");
    for (int g = 0; g < TIMEOUT; g++) begin
      cyc(1'b0, 1'($urandom));
      if (g < TIMEOUT - 1) chk("to_bsy", 16'(S_BSY), 16'd1);
    end
    all_zero("timeout");
    txn(16'h1001, 1'b1, 8'h3E, -1, 0);

    w0 = wen_cnt;
    B_RW = 1'b1;
    send(16'h1456, 16, -1, 0);
    window(1'b1, 1'b0, 12'h456, 8'h00);
    send(16'h00C3, 4, -1, 0);
    B_UTIL = 1'b0;
    #2 RSTN = 1'b0;
    #1 all_zero("rst_async");
    @(negedge CLK);
    all_zero("rst_hold");
    chk("rst_no_wen", 16'(wen_cnt - w0), 16'd0);
    RSTN = 1'b1;
    @(negedge CLK);
    txn(16'h1456, 1'b1, 8'hC3, -1, 0);
    txn(16'h1456, 1'b0, 8'h00, 2, 3);

    for (int n = 0; n < 12; n++) begin
      a = {4'h1, 9'h000, 3'($urandom)};
      if ($urandom_range(0, 3) == 0) a[15:12] = 4'($urandom);
      txn(a, 1'($urandom), 8'($urandom),
          ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 6)),
          int'($urandom_range(1, TIMEOUT - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
